bilateral_window_fetch: RTL and testbench

Raster-order pixel fetcher and 5x5 window former that sits directly upstream of the bilateral filter core. It drives the 16-bit pixel read address to the image memory (testbench-modelled), consumes the returned 8-bit pixel, and keeps four 256-byte line buffers plus a 5x5 register window. It emits one complete window per interior centre pixel to the filter core over a valid/ready handshake.

---
 rtl/bilateral_window_fetch_if.sv | 25 ++
 rtl/bilateral_window_fetch.sv | 142 ++++++++++++++
 tb/tb_bilateral_window_fetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bilateral_window_fetch_if.sv
// rtl/bilateral_window_fetch_if.sv - pixel-fetch and window-handshake signal bundle
interface bilateral_window_fetch_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic            in_valid;
  logic [AW-1:0]   in_addr;
  logic [DW-1:0]   in_data;
  logic            win_valid;
  logic            win_ready;
  logic [AW-1:0]   win_addr;
  logic [25*DW-1:0] win_data;

  // Fetcher side: drives the read address and the window, consumes pixels.
  modport master (
    input  in_valid, in_data, win_ready,
    output in_addr, win_valid, win_addr, win_data
  );

  // Memory model / filter core side.
  modport slave (
    output in_valid, in_data, win_ready,
    input  in_addr, win_valid, win_addr, win_data
  );
endinterface

// File: rtl/bilateral_window_fetch.sv
// rtl/bilateral_window_fetch.sv - raster pixel fetcher and 5x5 window former (optional WINFETCH_PERF_EN stall counter)
module bilateral_window_fetch #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int AW    = 16,
  parameter int DW    = 8
) (
  input  logic clk,
  input  logic rst,
  bilateral_window_fetch_if.master bus,
  output logic fetch_done
`ifdef WINFETCH_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int            CW   = $clog2(IMG_W);
  localparam int            RW   = AW - CW;
  localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] CTR_OFS = AW'(2 * IMG_W + 2);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-1:0]    r_in_addr;
  logic             r_win_valid;
  logic [AW-1:0]    r_win_addr;
  logic [25*DW-1:0] r_win_data;

  // Four previous rows, indexed by column; lb[0] is the oldest row (r-4).
  logic [DW-1:0] r_lb [4][IMG_W];

  logic             w_stall;
  logic             w_consume;
  logic [RW-1:0]    w_row;
  logic [CW-1:0]    w_col;
  logic             w_win_hit;
  logic             w_win_valid_nxt;
  logic [DW-1:0]    w_new_col [5];
  logic [25*DW-1:0] w_win_shift;

  assign w_stall   = r_win_valid & ~bus.win_ready;
  assign w_consume = bus.in_valid & ~w_stall & (r_state == S_RUN);
  assign w_row     = r_in_addr[AW-1:CW];
  assign w_col     = r_in_addr[CW-1:0];
  // Columns 0..3 of a row still hold the previous row's tail, so they never complete a window.
  assign w_win_hit = (w_row >= RW'(4)) && (w_col >= CW'(4));

  // Assemble the incoming column (oldest row at top) and shift the window left by one.
  always_comb begin
    w_new_col[0] = r_lb[0][w_col];
    w_new_col[1] = r_lb[1][w_col];
    w_new_col[2] = r_lb[2][w_col];
    w_new_col[3] = r_lb[3][w_col];
    w_new_col[4] = bus.in_data;
    w_win_shift  = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_win_shift[DW*(5*i+j) +: DW] = r_win_data[DW*(5*i+j+1) +: DW];
      end
      w_win_shift[DW*(5*i+4) +: DW] = w_new_col[i];
    end
  end

  // Next state and next window-valid: RUN until the last pixel, DRAIN until the last window is taken.
  always_comb begin
    w_state_nxt     = r_state;
    w_win_valid_nxt = w_stall;
    if (w_consume) begin
      w_win_valid_nxt = w_win_hit;
      if (r_in_addr == LAST) begin
        w_state_nxt = S_DRAIN;
      end
    end
    if ((r_state == S_DRAIN) && r_win_valid && bus.win_ready) begin
      w_state_nxt = S_DONE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read address and window output registers; everything holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_addr   <= '0;
      r_win_valid <= 1'b0;
      r_win_addr  <= '0;
      r_win_data  <= '0;
    end else begin
      r_win_valid <= w_win_valid_nxt;
      if (w_consume) begin
        if (r_in_addr != LAST) begin
          r_in_addr <= r_in_addr + AW'(1);
        end
        r_win_addr <= r_in_addr - CTR_OFS;
        r_win_data <= w_win_shift;
      end
    end
  end

  // Line buffers roll the column up one row and take the new pixel at the bottom; no reset needed.
  always_ff @(posedge clk) begin
    if (w_consume) begin
      r_lb[0][w_col] <= r_lb[1][w_col];
      r_lb[1][w_col] <= r_lb[2][w_col];
      r_lb[2][w_col] <= r_lb[3][w_col];
      r_lb[3][w_col] <= bus.in_data;
    end
  end

`ifdef WINFETCH_PERF_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles where a pixel was available but the window was not taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && bus.in_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign bus.in_addr   = r_in_addr;
  assign bus.win_valid = r_win_valid;
  assign bus.win_addr  = r_win_addr;
  assign bus.win_data  = r_win_data;
  assign fetch_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_bilateral_window_fetch.sv
// tb/tb_bilateral_window_fetch.sv - directed self-checking bench for bilateral_window_fetch
module tb_bilateral_window_fetch;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk;
  logic rst;
  logic fetch_done;
`ifdef WINFETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  bilateral_window_fetch_if #(.AW(AW), .DW(DW)) bus ();

  bilateral_window_fetch #(.IMG_W(256), .IMG_H(256), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fetch_done (fetch_done)
`ifdef WINFETCH_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // Ramp image: mem[a] = a % 256, answered combinationally for the held address.
  assign bus.in_data = bus.in_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window scoreboard: every accepted window checked against the ramp image.
  int          nwin;
  int          snap_n = -1;
  int          exp_r;
  int          exp_c;
  logic [31:0] csum;
  logic [31:0] snap_csum;
  logic [15:0] last_addr;
  bit          mon_bad = 0;
  bit          px_ok;

  always @(negedge clk) begin
    if (!rst) begin
      nwin  = 0;
      csum  = 0;
      exp_r = 2;
      exp_c = 2;
    end else if (bus.win_valid && bus.win_ready) begin
      if (!mon_bad) begin
        px_ok = 1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            if (bus.win_data[8*(5*i+j) +: 8] !== 8'(exp_c - 2 + j)) px_ok = 0;
        check("win_addr_seq", {16'b0, bus.win_addr}, exp_r * 256 + exp_c);
        check("win_data_seq", {31'b0, px_ok}, 1);
        if ((bus.win_addr !== 16'(exp_r * 256 + exp_c)) || !px_ok) mon_bad = 1;
      end
      csum = {csum[30:0], csum[31]} ^ {16'b0, bus.win_addr} ^ bus.win_data[31:0] ^ bus.win_data[199:168];
      nwin++;
      last_addr = bus.win_addr;
      if (nwin == snap_n) snap_csum = csum;
      exp_c++;
      if (exp_c > 253) begin
        exp_c = 2;
        exp_r++;
      end
    end
  end

  int               cnt;
  int               run1_n;
  logic [31:0]      run1_csum;
  logic [25*DW-1:0] saved;
  bit               found;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.win_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_in_addr", {16'b0, bus.in_addr}, 0);
    check("rst_win_valid", {31'b0, bus.win_valid}, 0);
    check("rst_win_addr", {16'b0, bus.win_addr}, 0);
    check("rst_win_data_zero", {31'b0, (bus.win_data == '0)}, 1);
    check("rst_fetch_done", {31'b0, fetch_done}, 0);

    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;

    // First window appears after the 1029th consuming edge, held by win_ready=0.
    cnt   = 0;
    found = 0;
    for (int k = 0; k < 1200; k++) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.win_valid) begin
        found = 1;
        break;
      end
    end
    check("first_found", {31'b0, found}, 1);
    check("first_edges", cnt, 1029);
    check("first_win_addr", {16'b0, bus.win_addr}, 514);
    check("first_in_addr", {16'b0, bus.in_addr}, 1029);
    check("first_px0", {24'b0, bus.win_data[7:0]}, 0);
    check("first_px12", {24'b0, bus.win_data[103:96]}, 2);
    check("first_px24", {24'b0, bus.win_data[199:192]}, 4);

    // Backpressure: three stalled cycles with everything frozen.
    saved = bus.win_data;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall_in_addr", {16'b0, bus.in_addr}, 1029);
      check("stall_win_valid", {31'b0, bus.win_valid}, 1);
      check("stall_win_addr", {16'b0, bus.win_addr}, 514);
      check("stall_win_data", {31'b0, (bus.win_data === saved)}, 1);
    end
    bus.win_ready = 1'b1;
    @(posedge clk); #1;
    check("after_stall_win_addr", {16'b0, bus.win_addr}, 515);
    check("after_stall_valid", {31'b0, bus.win_valid}, 1);

    // Row wrap: window 765 then exactly four idle cycles before 770.
    found = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (bus.win_valid && (bus.win_addr == 16'd765)) begin
        found = 1;
        break;
      end
    end
    check("wrap_found_765", {31'b0, found}, 1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.win_valid) break;
      cnt++;
    end
    check("wrap_gap", cnt, 4);
    check("wrap_win_addr", {16'b0, bus.win_addr}, 770);
    check("wrap_px0", {24'b0, bus.win_data[7:0]}, 0);
    check("wrap_px24", {24'b0, bus.win_data[199:192]}, 4);

    // Seven more stalled cycles on window 770 (in_addr 1285), ten in total.
    bus.win_ready = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("stall7_win_addr", {16'b0, bus.win_addr}, 770);
    check("stall7_in_addr", {16'b0, bus.in_addr}, 1285);
`ifdef WINFETCH_PERF_EN
    check("stall_cnt_10", {16'b0, stall_cnt}, 10);
`endif
    bus.win_ready = 1'b1;

    // in_valid low: pending window 771 still handshakes, no pixel consumed.
    @(posedge clk); #1;
    check("inv_win_addr", {16'b0, bus.win_addr}, 771);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("inv_valid_drop", {31'b0, bus.win_valid}, 0);
    check("inv_in_addr", {16'b0, bus.in_addr}, 1286);
    @(posedge clk); #1;
    check("inv_in_addr_hold", {16'b0, bus.in_addr}, 1286);
    bus.in_valid = 1'b1;

    // Run on to in_addr 30000, then reset mid-operation.
    found = 0;
    for (int k = 0; k < 30000; k++) begin
      @(negedge clk);
      if (bus.in_addr == 16'd30000) begin
        found = 1;
        break;
      end
    end
    check("reach_30000", {31'b0, found}, 1);
    #1;
    run1_n    = nwin;
    run1_csum = csum;
    rst = 1'b0;
    #1;
    check("mid_rst_in_addr", {16'b0, bus.in_addr}, 0);
    check("mid_rst_win_valid", {31'b0, bus.win_valid}, 0);
    check("mid_rst_win_addr", {16'b0, bus.win_addr}, 0);
    check("mid_rst_fetch_done", {31'b0, fetch_done}, 0);
`ifdef WINFETCH_PERF_EN
    check("mid_rst_stall_cnt", {16'b0, stall_cnt}, 0);
`endif
    snap_n = run1_n;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Full run with win_ready held high.
    found = 0;
    for (int k = 0; k < 70000; k++) begin
      @(posedge clk); #1;
      if (fetch_done) begin
        found = 1;
        break;
      end
    end
    check("fetch_done_seen", {31'b0, found}, 1);
    check("window_count", nwin, 63504);
    check("last_win_addr", {16'b0, last_addr}, 65021);
    check("rerun_signature", snap_csum, run1_csum);
    check("done_in_addr", {16'b0, bus.in_addr}, 65535);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold_in_addr", {16'b0, bus.in_addr}, 65535);
    check("done_hold_valid", {31'b0, bus.win_valid}, 0);
    check("done_hold_level", {31'b0, fetch_done}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
